// File: rtl/ama_riscv_defines_pkg.sv
// Shared encodings for the AMA RISC-V execute stage: ALU opcodes, mux selects,
// DMEM byte masks and the EX/MEM pipeline record.
package ama_riscv_defines_pkg;

    localparam int XLEN = 32;
    localparam int SHAMT_W = 5;
    localparam int DMEM_ADDR_MSB = 15;
    localparam int DMEM_ADDR_LSB = 2;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'b0000,
        ALU_SUB    = 4'b1000,
        ALU_SLL    = 4'b0001,
        ALU_SLT    = 4'b0010,
        ALU_SLTU   = 4'b0011,
        ALU_XOR    = 4'b0100,
        ALU_SRL    = 4'b0101,
        ALU_SRA    = 4'b1101,
        ALU_OR     = 4'b0110,
        ALU_AND    = 4'b0111,
        ALU_PASS_B = 4'b1111
    } alu_op_t;

    localparam logic [1:0] ALU_A_SEL_RS1     = 2'd0;
    localparam logic [1:0] ALU_A_SEL_PC      = 2'd1;
    localparam logic [1:0] ALU_A_SEL_FWD     = 2'd2;
    localparam logic [1:0] ALU_B_SEL_RS2     = 2'd0;
    localparam logic [1:0] ALU_B_SEL_IMM     = 2'd1;
    localparam logic [1:0] ALU_B_SEL_FWD     = 2'd2;

    localparam logic BC_SEL_REG = 1'b0;
    localparam logic BC_SEL_FWD = 1'b1;

    localparam logic [3:0] DMEM_WE_NONE = 4'b0000;
    localparam logic [3:0] DMEM_WE_BYTE = 4'b0001;
    localparam logic [3:0] DMEM_WE_HALF = 4'b0011;
    localparam logic [3:0] DMEM_WE_WORD = 4'b1111;

    localparam logic [1:0] OFFSET_ALIGNED = 2'd0;
    localparam logic [1:0] OFFSET_LAST    = 2'd3;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] alu_out;
        logic [XLEN-1:0] inst;
        logic [4:0]      rd_addr;
        logic            reg_we;
        logic [1:0]      wb_sel;
        logic            load_sm_en;
        logic [1:0]      load_offset;
    } ex_mem_t;

endpackage

// File: rtl/ama_riscv_alu.sv
// Combinational integer ALU; unknown opcodes produce zero.
module ama_riscv_alu
    import ama_riscv_defines_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      op_sel,
    output logic [XLEN-1:0] result
);

    logic [SHAMT_W-1:0] shamt;

    assign shamt = b[SHAMT_W-1:0];

    always_comb begin
        result = '0;
        case (alu_op_t'(op_sel))
            ALU_ADD:    result = a + b;
            ALU_SUB:    result = a - b;
            ALU_SLL:    result = a << shamt;
            ALU_SLT:    result = XLEN'($signed(a) < $signed(b));
            ALU_SLTU:   result = XLEN'(a < b);
            ALU_XOR:    result = a ^ b;
            ALU_SRL:    result = a >> shamt;
            ALU_SRA:    result = $signed(a) >>> shamt;
            ALU_OR:     result = a | b;
            ALU_AND:    result = a & b;
            ALU_PASS_B: result = b;
            default:    result = '0;
        endcase
    end

endmodule

// File: rtl/ama_riscv_ex_stage.sv
// Execute stage: operand forwarding muxes, ALU, branch compare, store lane
// alignment and the EX/MEM pipeline register.
module ama_riscv_ex_stage
    import ama_riscv_defines_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_ex,
    input  logic [XLEN-1:0] rs1_data_ex,
    input  logic [XLEN-1:0] rs2_data_ex,
    input  logic [XLEN-1:0] imm_gen_out_ex,
    input  logic [XLEN-1:0] inst_ex,
    input  logic [4:0]      rd_addr_ex,
    input  logic            reg_we_ex,
    input  logic [1:0]      alu_a_sel_fwd_ex,
    input  logic [1:0]      alu_b_sel_fwd_ex,
    input  logic            bc_a_sel_fwd_ex,
    input  logic            bcs_b_sel_fwd_ex,
    input  logic            bc_uns_ex,
    input  logic [3:0]      alu_op_sel_ex,
    input  logic [1:0]      wb_sel_ex,
    input  logic            load_sm_en_ex,
    input  logic            dmem_en_ex,
    input  logic [3:0]      dmem_we_ex,
    input  logic [XLEN-1:0] writeback_fwd,
    input  logic            clear_ex,
    output logic [XLEN-1:0] alu_out,
    output logic            bc_a_eq_b,
    output logic            bc_a_lt_b,
    output logic [1:0]      store_mask_offset,
    output logic            dmem_en,
    output logic [13:0]     dmem_addr,
    output logic [3:0]      dmem_we,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [XLEN-1:0] pc_mem,
    output logic [XLEN-1:0] alu_out_mem,
    output logic [XLEN-1:0] inst_mem,
    output logic [4:0]      rd_addr_mem,
    output logic            reg_we_mem,
    output logic [1:0]      wb_sel_mem,
    output logic            load_sm_en_mem,
    output logic [1:0]      load_offset_mem
);

    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] bc_a;
    logic [XLEN-1:0] bc_b;
    logic [1:0]      offset;
    logic            store_misaligned;
    ex_mem_t         ex_mem_d;
    ex_mem_t         ex_mem_q;

    always_comb begin
        case (alu_a_sel_fwd_ex)
            ALU_A_SEL_PC:  alu_a = pc_ex;
            ALU_A_SEL_FWD: alu_a = writeback_fwd;
            default:       alu_a = rs1_data_ex;
        endcase
        case (alu_b_sel_fwd_ex)
            ALU_B_SEL_IMM: alu_b = imm_gen_out_ex;
            ALU_B_SEL_FWD: alu_b = writeback_fwd;
            default:       alu_b = rs2_data_ex;
        endcase
    end

    ama_riscv_alu u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op_sel (alu_op_sel_ex),
        .result (alu_out)
    );

    // Compare operand B doubles as store data, so forwarding covers both.
    assign bc_a = (bc_a_sel_fwd_ex == BC_SEL_FWD) ? writeback_fwd : rs1_data_ex;
    assign bc_b = (bcs_b_sel_fwd_ex == BC_SEL_FWD) ? writeback_fwd : rs2_data_ex;

    assign bc_a_eq_b = (bc_a == bc_b);
    assign bc_a_lt_b = bc_uns_ex ? (bc_a < bc_b) : ($signed(bc_a) < $signed(bc_b));

    assign offset            = alu_out[1:0];
    assign store_mask_offset = offset;

    assign store_misaligned =
        ((dmem_we_ex == DMEM_WE_HALF) && (offset == OFFSET_LAST)) ||
        ((dmem_we_ex == DMEM_WE_WORD) && (offset != OFFSET_ALIGNED));

    assign dmem_en    = dmem_en_ex;
    assign dmem_addr  = alu_out[DMEM_ADDR_MSB:DMEM_ADDR_LSB];
    assign dmem_we    = store_misaligned ? DMEM_WE_NONE : (dmem_we_ex << offset);
    assign dmem_wdata = bc_b << {offset, 3'b000};

    always_comb begin
        ex_mem_d = '0;
        if (!clear_ex) begin
            ex_mem_d.pc          = pc_ex;
            ex_mem_d.alu_out     = alu_out;
            ex_mem_d.inst        = inst_ex;
            ex_mem_d.rd_addr     = rd_addr_ex;
            ex_mem_d.reg_we      = reg_we_ex;
            ex_mem_d.wb_sel      = wb_sel_ex;
            ex_mem_d.load_sm_en  = load_sm_en_ex;
            ex_mem_d.load_offset = offset;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_mem_q <= '0;
        end else begin
            ex_mem_q <= ex_mem_d;
        end
    end

    assign pc_mem          = ex_mem_q.pc;
    assign alu_out_mem     = ex_mem_q.alu_out;
    assign inst_mem        = ex_mem_q.inst;
    assign rd_addr_mem     = ex_mem_q.rd_addr;
    assign reg_we_mem      = ex_mem_q.reg_we;
    assign wb_sel_mem      = ex_mem_q.wb_sel;
    assign load_sm_en_mem  = ex_mem_q.load_sm_en;
    assign load_offset_mem = ex_mem_q.load_offset;

endmodule

// File: tb/tb_ama_riscv_ex_stage.sv
// Self-checking bench for ama_riscv_ex_stage: directed cases plus randomized
// traffic checked against a plain-arithmetic reference model.
module tb_ama_riscv_ex_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic        we;
        logic [1:0]  wb;
        logic        sm;
        logic [1:0]  off;
    } mem_t;

    logic        clk;
    logic        rst;
    logic [31:0] pc_ex, rs1_data_ex, rs2_data_ex, imm_gen_out_ex, inst_ex;
    logic [4:0]  rd_addr_ex;
    logic        reg_we_ex;
    logic [1:0]  alu_a_sel_fwd_ex, alu_b_sel_fwd_ex;
    logic        bc_a_sel_fwd_ex, bcs_b_sel_fwd_ex, bc_uns_ex;
    logic [3:0]  alu_op_sel_ex;
    logic [1:0]  wb_sel_ex;
    logic        load_sm_en_ex;
    logic        dmem_en_ex;
    logic [3:0]  dmem_we_ex;
    logic [31:0] writeback_fwd;
    logic        clear_ex;
    logic [31:0] alu_out;
    logic        bc_a_eq_b, bc_a_lt_b;
    logic [1:0]  store_mask_offset;
    logic        dmem_en;
    logic [13:0] dmem_addr;
    logic [3:0]  dmem_we;
    logic [31:0] dmem_wdata;
    logic [31:0] pc_mem, alu_out_mem, inst_mem;
    logic [4:0]  rd_addr_mem;
    logic        reg_we_mem;
    logic [1:0]  wb_sel_mem;
    logic        load_sm_en_mem;
    logic [1:0]  load_offset_mem;

    mem_t got_mem;
    assign got_mem = {pc_mem, alu_out_mem, inst_mem, rd_addr_mem, reg_we_mem,
                      wb_sel_mem, load_sm_en_mem, load_offset_mem};

    int total = 0;
    int bad = 0;

    // Reference-model results
    logic [31:0] exp_alu;
    logic        exp_eq, exp_lt;
    logic [3:0]  exp_we;
    logic [31:0] exp_wdata;
    mem_t        exp_mem;

    ama_riscv_ex_stage dut (
        .clk               (clk),
        .rst               (rst),
        .pc_ex             (pc_ex),
        .rs1_data_ex       (rs1_data_ex),
        .rs2_data_ex       (rs2_data_ex),
        .imm_gen_out_ex    (imm_gen_out_ex),
        .inst_ex           (inst_ex),
        .rd_addr_ex        (rd_addr_ex),
        .reg_we_ex         (reg_we_ex),
        .alu_a_sel_fwd_ex  (alu_a_sel_fwd_ex),
        .alu_b_sel_fwd_ex  (alu_b_sel_fwd_ex),
        .bc_a_sel_fwd_ex   (bc_a_sel_fwd_ex),
        .bcs_b_sel_fwd_ex  (bcs_b_sel_fwd_ex),
        .bc_uns_ex         (bc_uns_ex),
        .alu_op_sel_ex     (alu_op_sel_ex),
        .wb_sel_ex         (wb_sel_ex),
        .load_sm_en_ex     (load_sm_en_ex),
        .dmem_en_ex        (dmem_en_ex),
        .dmem_we_ex        (dmem_we_ex),
        .writeback_fwd     (writeback_fwd),
        .clear_ex          (clear_ex),
        .alu_out           (alu_out),
        .bc_a_eq_b         (bc_a_eq_b),
        .bc_a_lt_b         (bc_a_lt_b),
        .store_mask_offset (store_mask_offset),
        .dmem_en           (dmem_en),
        .dmem_addr         (dmem_addr),
        .dmem_we           (dmem_we),
        .dmem_wdata        (dmem_wdata),
        .pc_mem            (pc_mem),
        .alu_out_mem       (alu_out_mem),
        .inst_mem          (inst_mem),
        .rd_addr_mem       (rd_addr_mem),
        .reg_we_mem        (reg_we_mem),
        .wb_sel_mem        (wb_sel_mem),
        .load_sm_en_mem    (load_sm_en_mem),
        .load_offset_mem   (load_offset_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
        int s;
        logic [31:0] ones;
        s = int'(b[4:0]);
        ones = 32'hFFFF_FFFF;
        case (op)
            4'd0:  return a + b;
            4'd8:  return a + (~b) + 32'd1;
            4'd1:  return a * (32'd1 << s);
            4'd2:  return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
            4'd3:  return {31'd0, a < b};
            4'd4:  return (a | b) & ~(a & b);
            4'd5:  return a / (32'd1 << s);
            4'd13: return a[31] ? ((a >> s) | ~(ones >> s)) : (a >> s);
            4'd6:  return a | b;
            4'd7:  return a & b;
            4'd15: return b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_eval();
        logic [31:0] a, b, ca, cb;
        int off, n;
        a  = (alu_a_sel_fwd_ex == 2'd1) ? pc_ex :
             (alu_a_sel_fwd_ex == 2'd2) ? writeback_fwd : rs1_data_ex;
        b  = (alu_b_sel_fwd_ex == 2'd1) ? imm_gen_out_ex :
             (alu_b_sel_fwd_ex == 2'd2) ? writeback_fwd : rs2_data_ex;
        ca = bc_a_sel_fwd_ex ? writeback_fwd : rs1_data_ex;
        cb = bcs_b_sel_fwd_ex ? writeback_fwd : rs2_data_ex;
        exp_alu = ref_alu(a, b, alu_op_sel_ex);
        exp_eq  = (ca == cb);
        if (bc_uns_ex) exp_lt = (ca < cb);
        else exp_lt = (ca[31] != cb[31]) ? ca[31] : (ca < cb);
        off = int'(exp_alu[1:0]);
        n = 0;
        for (int i = 0; i < 4; i++) if (dmem_we_ex[i]) n++;
        exp_we = 4'b0000;
        if (n != 0 && off + n <= 4)
            for (int i = 0; i < n; i++) exp_we[off + i] = 1'b1;
        exp_wdata = 32'd0;
        for (int i = 0; i < 4; i++)
            if (i >= off) exp_wdata[8*i +: 8] = cb[8*(i-off) +: 8];
        exp_mem = '{pc_ex, exp_alu, inst_ex, rd_addr_ex, reg_we_ex,
                    wb_sel_ex, load_sm_en_ex, exp_alu[1:0]};
    endtask

    task automatic rand_inputs();
        logic [3:0] ops [12];
        logic [3:0] wes [4];
        ops = '{4'd0, 4'd8, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd13, 4'd6, 4'd7, 4'd15, 4'd9};
        wes = '{4'b0000, 4'b0001, 4'b0011, 4'b1111};
        pc_ex            = $urandom;
        rs1_data_ex      = $urandom;
        rs2_data_ex      = ($urandom_range(0, 3) == 0) ? rs1_data_ex : $urandom;
        imm_gen_out_ex   = $urandom;
        inst_ex          = $urandom;
        rd_addr_ex       = 5'($urandom);
        reg_we_ex        = 1'($urandom);
        alu_a_sel_fwd_ex = 2'($urandom);
        alu_b_sel_fwd_ex = 2'($urandom);
        bc_a_sel_fwd_ex  = 1'($urandom);
        bcs_b_sel_fwd_ex = 1'($urandom);
        bc_uns_ex        = 1'($urandom);
        alu_op_sel_ex    = ops[$urandom_range(0, 11)];
        wb_sel_ex        = 2'($urandom);
        load_sm_en_ex    = 1'($urandom);
        dmem_en_ex       = 1'($urandom);
        dmem_we_ex       = wes[$urandom_range(0, 3)];
        writeback_fwd    = $urandom;
        clear_ex         = 1'b0;
        rst              = 1'b0;
    endtask

    task automatic clear_inputs();
        pc_ex = 0; rs1_data_ex = 0; rs2_data_ex = 0; imm_gen_out_ex = 0; inst_ex = 0;
        rd_addr_ex = 0; reg_we_ex = 0; alu_a_sel_fwd_ex = 0; alu_b_sel_fwd_ex = 0;
        bc_a_sel_fwd_ex = 0; bcs_b_sel_fwd_ex = 0; bc_uns_ex = 0; alu_op_sel_ex = 0;
        wb_sel_ex = 0; load_sm_en_ex = 0; dmem_en_ex = 0; dmem_we_ex = 0;
        writeback_fwd = 0; clear_ex = 0; rst = 0;
    endtask

    task automatic test_reset();
        rand_inputs();
        reg_we_ex = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if (got_mem !== '0) begin
            bad++;
            $display("FAIL reset_state got=%h exp=0", got_mem);
        end else $display("reset_state mem=%h", got_mem);
        rst = 1'b0;
    endtask

    task automatic test_add_forward();
        clear_inputs();
        alu_a_sel_fwd_ex = 2'd2; writeback_fwd = 32'h10;
        alu_b_sel_fwd_ex = 2'd1; imm_gen_out_ex = 32'h4; alu_op_sel_ex = 4'b0000;
        #3;
        total++;
        if (alu_out !== 32'h14) begin
            bad++; $display("FAIL add_fwd_comb got=%h exp=00000014", alu_out);
        end else $display("add_fwd_comb alu_out=%h", alu_out);
        @(posedge clk); #1;
        total++;
        if (alu_out_mem !== 32'h14) begin
            bad++; $display("FAIL add_fwd_mem got=%h exp=00000014", alu_out_mem);
        end else $display("add_fwd_mem alu_out_mem=%h", alu_out_mem);
    endtask

    task automatic test_compare();
        clear_inputs();
        rs1_data_ex = 32'hFFFF_FFFF; rs2_data_ex = 32'h1; bc_uns_ex = 1'b0;
        #3;
        total++;
        if ({bc_a_lt_b, bc_a_eq_b} !== 2'b10) begin
            bad++; $display("FAIL cmp_signed got lt/eq=%b%b exp=10", bc_a_lt_b, bc_a_eq_b);
        end else $display("cmp_signed lt=%b eq=%b", bc_a_lt_b, bc_a_eq_b);
        bc_uns_ex = 1'b1;
        #1;
        total++;
        if ({bc_a_lt_b, bc_a_eq_b} !== 2'b00) begin
            bad++; $display("FAIL cmp_unsigned got lt/eq=%b%b exp=00", bc_a_lt_b, bc_a_eq_b);
        end else $display("cmp_unsigned lt=%b eq=%b", bc_a_lt_b, bc_a_eq_b);
        @(posedge clk); #1;
    endtask

    task automatic test_store();
        clear_inputs();
        rs1_data_ex = 32'h1001; imm_gen_out_ex = 32'h0; alu_b_sel_fwd_ex = 2'd1;
        dmem_en_ex = 1'b1; dmem_we_ex = 4'b0001; rs2_data_ex = 32'hAB;
        #3;
        total++;
        if ({dmem_we, dmem_wdata, dmem_addr, dmem_en} !== {4'b0010, 32'h0000_AB00, 14'h400, 1'b1}) begin
            bad++;
            $display("FAIL byte_store got we=%b wdata=%h addr=%h en=%b exp we=0010 wdata=0000ab00 addr=0400 en=1",
                     dmem_we, dmem_wdata, dmem_addr, dmem_en);
        end else $display("byte_store we=%b wdata=%h addr=%h", dmem_we, dmem_wdata, dmem_addr);
        rs1_data_ex = 32'h2; dmem_we_ex = 4'b1111;
        #1;
        total++;
        if ({dmem_we, dmem_en} !== {4'b0000, 1'b1}) begin
            bad++; $display("FAIL misaligned_word got we=%b en=%b exp we=0000 en=1", dmem_we, dmem_en);
        end else $display("misaligned_word we=%b", dmem_we);
        rs1_data_ex = 32'h3; dmem_we_ex = 4'b0011;
        #1;
        total++;
        if (dmem_we !== 4'b0000) begin
            bad++; $display("FAIL misaligned_half got we=%b exp=0000", dmem_we);
        end else $display("misaligned_half we=%b", dmem_we);
        rs1_data_ex = 32'h2;
        #1;
        total++;
        if (dmem_we !== 4'b1100) begin
            bad++; $display("FAIL half_offset2 got we=%b exp=1100", dmem_we);
        end else $display("half_offset2 we=%b", dmem_we);
        @(posedge clk); #1;
    endtask

    task automatic test_sra();
        clear_inputs();
        rs1_data_ex = 32'h8000_0000; alu_b_sel_fwd_ex = 2'd1;
        imm_gen_out_ex = 32'h24; alu_op_sel_ex = 4'b1101;
        #3;
        total++;
        if (alu_out !== 32'hF800_0000) begin
            bad++; $display("FAIL sra got=%h exp=f8000000", alu_out);
        end else $display("sra alu_out=%h", alu_out);
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        rand_inputs();
        reg_we_ex = 1'b1; rd_addr_ex = 5'd5; clear_ex = 1'b1;
        model_eval();
        #3;
        total++;
        if ({dmem_we, dmem_wdata, alu_out} !== {exp_we, exp_wdata, exp_alu}) begin
            bad++; $display("FAIL flush_comb got we=%b wdata=%h alu=%h exp we=%b wdata=%h alu=%h",
                            dmem_we, dmem_wdata, alu_out, exp_we, exp_wdata, exp_alu);
        end else $display("flush_comb alu=%h we=%b", alu_out, dmem_we);
        @(posedge clk); #1;
        total++;
        if ({reg_we_mem, rd_addr_mem} !== 6'd0 || got_mem !== '0) begin
            bad++; $display("FAIL flush_bubble got=%h exp=0", got_mem);
        end else $display("flush_bubble reg_we_mem=%b rd=%0d", reg_we_mem, rd_addr_mem);
        rand_inputs();
        @(posedge clk); #1;
        rand_inputs();
        rst = 1'b1; clear_ex = 1'b1;
        @(posedge clk); #1;
        total++;
        if (got_mem !== '0) begin
            bad++; $display("FAIL rst_and_clear got=%h exp=0", got_mem);
        end else $display("rst_and_clear mem=%h", got_mem);
        rst = 1'b0; clear_ex = 1'b0;
    endtask

    task automatic test_random(input int n);
        for (int t = 0; t < n; t++) begin
            rand_inputs();
            model_eval();
            #3;
            total++;
            if ({alu_out, bc_a_eq_b, bc_a_lt_b, store_mask_offset, dmem_en, dmem_addr, dmem_we, dmem_wdata} !==
                {exp_alu, exp_eq, exp_lt, exp_alu[1:0], dmem_en_ex, exp_alu[15:2], exp_we, exp_wdata}) begin
                bad++;
                $display("FAIL rand_comb[%0d] op=%b got alu=%h eq=%b lt=%b we=%b wdata=%h addr=%h exp alu=%h eq=%b lt=%b we=%b wdata=%h addr=%h",
                         t, alu_op_sel_ex, alu_out, bc_a_eq_b, bc_a_lt_b, dmem_we, dmem_wdata, dmem_addr,
                         exp_alu, exp_eq, exp_lt, exp_we, exp_wdata, exp_alu[15:2]);
            end
            @(posedge clk); #1;
            total++;
            if (got_mem !== exp_mem) begin
                bad++; $display("FAIL rand_mem[%0d] got=%h exp=%h", t, got_mem, exp_mem);
            end else $display("rand[%0d] op=%b alu=%h we=%b mem ok", t, alu_op_sel_ex, exp_alu, exp_we);
        end
    endtask

    task automatic test_back_to_back(input int n);
        mem_t want;
        for (int t = 0; t < n; t++) begin
            rand_inputs();
            clear_ex = ($urandom_range(0, 4) == 0);
            rst      = ($urandom_range(0, 6) == 0);
            model_eval();
            want = (rst || clear_ex) ? mem_t'(0) : exp_mem;
            @(posedge clk); #1;
            total++;
            if (got_mem !== want) begin
                bad++; $display("FAIL b2b[%0d] rst=%b clr=%b got=%h exp=%h", t, rst, clear_ex, got_mem, want);
            end else $display("b2b[%0d] rst=%b clr=%b mem=%h", t, rst, clear_ex, got_mem);
        end
        rst = 1'b0; clear_ex = 1'b0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_add_forward();
        test_compare();
        test_store();
        test_sra();
        test_flush();
        test_random(200);
        test_back_to_back(40);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ama_riscv_ex_stage.md
AMA_RISCV_EX_STAGE -- requirements
Module: ama_riscv_ex_stage

Interface
REQ-001 clk  in  1  core clock; all state updates on the rising edge.
REQ-002 rst  in  1  reset, synchronous and active-high.
REQ-003 pc_ex, rs1_data_ex, rs2_data_ex, imm_gen_out_ex, inst_ex  in  32 each  ID/EX pipeline datapath values.
REQ-004 rd_addr_ex  in  5  destination register; reg_we_ex  in  1  register write enable.
REQ-005 alu_a_sel_fwd_ex, alu_b_sel_fwd_ex  in  2 each; bc_a_sel_fwd_ex, bcs_b_sel_fwd_ex, bc_uns_ex  in  1 each.
REQ-006 alu_op_sel_ex  in  4  ALU opcode; wb_sel_ex  in  2  writeback select; load_sm_en_ex  in  1  load shift/mask enable.
REQ-007 dmem_en_ex  in  1  memory access; dmem_we_ex  in  4  unshifted byte mask (4'b0001 byte, 4'b0011 half, 4'b1111 word).
REQ-008 writeback_fwd  in  32  MEM-stage result used for forwarding; clear_ex  in  1  flush the EX/MEM register.
REQ-009 alu_out  out  32  combinational ALU result, also feeds the PC mux.
REQ-010 bc_a_eq_b, bc_a_lt_b  out  1 each  combinational branch compare; store_mask_offset  out  2  equals alu_out[1:0].
REQ-011 dmem_en, dmem_addr[13:0], dmem_we[3:0], dmem_wdata[31:0]  out  combinational DMEM port.
REQ-012 pc_mem, alu_out_mem, inst_mem  out  32; rd_addr_mem  out  5; reg_we_mem, load_sm_en_mem  out  1; wb_sel_mem  out  2; load_offset_mem  out  2  registered EX/MEM outputs.

Function
REQ-013 ALU operand A mux: 0 gives rs1_data_ex, 1 gives pc_ex, 2 gives writeback_fwd, 3 gives rs1_data_ex.
REQ-014 ALU operand B mux: 0 gives rs2_data_ex, 1 gives imm_gen_out_ex, 2 gives writeback_fwd, 3 gives rs2_data_ex.
REQ-015 ALU ops are ADD=0000, SUB=1000, SLL=0001, SLT=0010, SLTU=0011, XOR=0100, SRL=0101, SRA=1101, OR=0110, AND=0111, PASS_B=1111; any other code gives 0.
REQ-016 Shift amount is B[4:0]; SLT/SLTU yield 32'd1 or 32'd0; ADD/SUB wrap modulo 2^32 with no overflow flag.
REQ-017 Compare operand A is rs1_data_ex (sel 0) or writeback_fwd (sel 1); compare operand B is rs2_data_ex or writeback_fwd, selected by bcs_b_sel_fwd_ex.
REQ-018 bc_a_eq_b is A==B; bc_a_lt_b is a signed compare when bc_uns_ex=0 and an unsigned compare when bc_uns_ex=1.
REQ-019 Store data is compare operand B (forwarded when needed).
  - dmem_wdata = store data << (8*offset)
  - dmem_we = dmem_we_ex << offset, where offset is alu_out[1:0]
REQ-020 Misaligned store (half at offset 3, word at offset != 0): dmem_we forced to 4'b0000; dmem_en unchanged.
REQ-021 dmem_addr = alu_out[15:2]; dmem_en = dmem_en_ex.
REQ-022 EX/MEM register latency is 1 cycle.
  - alu_out_mem captures alu_out; load_offset_mem captures alu_out[1:0].
  - All other _mem outputs capture their _ex counterparts.
REQ-023 clear_ex (with rst low) loads all EX/MEM registers with 0, inserting a bubble with reg_we_mem=0; combinational DMEM outputs are unaffected.
REQ-024 Priority is rst > clear_ex > normal capture; the block has no stall input, and the register updates every cycle.

Reset
REQ-025 On rst, every EX/MEM output is 0 on the next edge: pc_mem, alu_out_mem, inst_mem, rd_addr_mem, reg_we_mem, wb_sel_mem, load_sm_en_mem and load_offset_mem.
REQ-026 Reset asserted mid-stream discards the in-flight instruction; no partial state survives.

Structure
REQ-027 ALU opcode, mux-select and byte-mask encodings live in the shared ama_riscv_defines file; no literals in RTL.
REQ-028 The ALU is the sub-module ama_riscv_alu (inputs a, b, op_sel; output result); muxes, compare, store alignment and the EX/MEM register stay in ama_riscv_ex_stage.

Verification
REQ-029 ADD forwarding: alu_a_sel=2, writeback_fwd=0x10, alu_b_sel=1, imm=0x4, op=ADD -> alu_out=0x14, and alu_out_mem=0x14 one cycle later.
REQ-030 Signed vs unsigned compare: rs1=0xFFFFFFFF, rs2=0x1, bc_uns=0 -> lt=1, eq=0; with bc_uns=1 -> lt=0.
REQ-031 Byte store: rs1=0x1001, imm=0, dmem_we_ex=0001, rs2=0xAB -> dmem_we=0010, dmem_wdata=0x0000AB00, dmem_addr=0x400.
REQ-032 Misaligned word store: address 0x2, dmem_we_ex=1111 -> dmem_we=0000.
REQ-033 SRA: A=0x80000000, B=0x24, op=SRA -> alu_out=0xF8000000 (shift amount 4).
REQ-034 Flush and reset: reg_we_ex=1, rd=5 with clear_ex=1 -> reg_we_mem=0, rd_addr_mem=0; rst and clear_ex both high -> all _mem outputs 0.
